mbyte_add_seq: RTL and testbench
================================

# mbyte_add_seq

Multi-byte sequential adder stage that feeds operand bytes, least-significant first, through an 8-bit add with carry-in and streams the sum bytes downstream. It sits directly upstream of the 8-bit result consumer in the datapath. It extends the combinational 8-bit `{overflow,sum}` add to NBYTES-wide operands by registering the carry between bytes. Both sides use valid/ready handshakes, and a single output register decouples them.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `clear`, input, 1: synchronous abort; drops the in-flight operand and any pending output.
- `in_valid`, input, 1: `in_a`/`in_b` hold a valid byte pair.
- `in_ready`, output, 1: stage accepts a byte pair this cycle.
- `in_a`, input, 8: operand A byte.
- `in_b`, input, 8: operand B byte.
- `out_valid`, output, 1: `out_sum` is valid.
- `out_ready`, input, 1: downstream accepts `out_sum`.
- `out_sum`, output, 8: sum byte.
- `out_last`, output, 1: `out_sum` is the most-significant byte of the operand.
- `carry_out`, output, 1: unsigned carry from the MS byte; valid only with `out_last`, otherwise 0.
- `ovf`, output, 1: signed two's-complement overflow of the full operand; valid only with `out_last`, otherwise 0.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (pipe register; no combinational path from `in_valid` to `in_ready`).
- Per accepted byte at index k:
  - Compute `{c, s} = in_a + in_b + carry_q` with a 9-bit result.
  - `out_sum <= s`.
  - `carry_q <= c`.
  - `out_last <= (k == NBYTES-1)`.
- Final byte:
  - `carry_out <= c`.
  - `ovf <= (in_a[7] == in_b[7]) && (s[7] != in_a[7])`.
  - `carry_q` clears to 0 so the next operand starts clean.
- Byte counter `cnt`:
  - Width `$clog2(NBYTES)`.
  - Increments on accept; wraps to 0 after NBYTES-1.
- FSM:
  - IDLE (`cnt==0`, `carry_q==0`). On accept: go to RUN, or stay IDLE if NBYTES has been reached on that accept.
  - RUN (mid-operand). On accept of byte NBYTES-1: go to IDLE. Otherwise stay in RUN.
- Output register:
  - `out_valid` sets on accept.
  - `out_valid` clears when `out_ready && !accept`.
  - On accept and `out_ready` in the same cycle, the register is replaced with no bubble.
  - Outputs hold stable while `out_valid && !out_ready`.
- `clear`:
  - Next edge: `cnt=0`, `carry_q=0`, `out_valid=0`, FSM to IDLE.
  - Any byte presented in that cycle is discarded, even if `in_ready` was high.
  - `clear` overrides accept.
- Reset values:
  - `out_valid`, `out_sum`, `out_last`, `carry_out`, `ovf`, `cnt`, `carry_q` = 0.
  - FSM = IDLE.
  - `in_ready` = 1, because it follows from `out_valid = 0`.
- Reset mid-operand: the partial operand is lost. The first byte accepted after reset is byte 0 with `carry_q = 0`.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 byte/cycle when `out_ready` is held high; one full operand every NBYTES cycles.
- Backpressure: with `out_valid=1` and `out_ready=0`, `in_ready=0` in the same cycle.
- Operand boundaries need no idle cycle; byte 0 of the next operand may be accepted the cycle after byte NBYTES-1.
- `reset` asserts asynchronously; deassertion is synchronized externally.

## Structure
- Shared package `add_pkg`:
  - `BYTE_W = 8`
  - typedef `byte_t` (logic [7:0])
  - FSM enum `add_state_e {IDLE, RUN}`
- One sub-module, `add8_ci`: combinational 8-bit add with carry-in.
  - Inputs: `a`, `b`, `ci`.
  - Outputs: `s`, `co`, `v` (signed overflow).
  - Instantiated once.
- The top holds the counter, carry register, FSM and output register.

## Test plan
- NBYTES=4, operands 0x000000FF + 0x00000001, `out_ready=1`:
  - `out_sum` sequence 0x00, 0x01, 0x00, 0x00.
  - `out_last` only on the 4th byte.
  - `carry_out=0`, `ovf=0`.
- 0xFFFFFFFF + 0x00000001:
  - All sum bytes 0x00.
  - `carry_out=1`, `ovf=0`.
  - The next operand 0x00000001 + 0x00000001 yields 0x02, 0x00, 0x00, 0x00 (carry not leaked).
- 0x7FFFFFFF + 0x00000001:
  - Bytes 0x00, 0x00, 0x00, 0x80.
  - `ovf=1`, `carry_out=0`.
- Backpressure: hold `out_ready=0` for 3 cycles after byte 1 is accepted.
  - `out_sum` stays stable.
  - `in_ready=0` throughout.
  - Release: no byte is lost or duplicated; the full sequence matches the reference sum.
- `clear` pulsed after byte 2 of 0x01010101 + 0x01010101:
  - `out_valid=0` on the next edge.
  - A new operand 0x00000003 + 0x00000004 yields 0x07, 0x00, 0x00, 0x00 with `out_last` on the 4th byte.
- Assert `reset` asynchronously mid-operand (between clock edges):
  - All outputs go to 0 immediately; `in_ready=1`.
  - After release, the first byte is treated as byte 0 with `carry_q=0`.

Source files
------------

// File: rtl/mbyte_add_seq_pkg.sv
// Shared types for the multi-byte sequential adder slice.
//   BYTE_W      : datapath byte width
//   byte_t      : one operand / sum byte
//   add_state_e : operand-sequencing FSM states
package add_pkg;
   localparam int BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic {
      IDLE = 1'b0,  // waiting for byte 0 of an operand
      RUN  = 1'b1   // mid-operand, carry_q may be live
   } add_state_e;
endpackage

// File: rtl/mbyte_add_seq_if.sv
// Byte-stream bus for mbyte_add_seq.
//   in_valid/in_ready/in_a/in_b                : operand byte pair, LS byte first
//   out_valid/out_ready/out_sum/out_last       : sum byte stream
//   carry_out/ovf                              : operand flags, qualified by out_last
// slave  = the adder stage, master = whoever drives operands and sinks sums.
interface mbyte_add_seq_if;
   import add_pkg::*;

   logic  in_valid;
   logic  in_ready;
   byte_t in_a;
   byte_t in_b;
   logic  out_valid;
   logic  out_ready;
   byte_t out_sum;
   logic  out_last;
   logic  carry_out;
   logic  ovf;

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_last, carry_out, ovf
   );

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_last, carry_out, ovf
   );
endinterface

// File: rtl/mbyte_add_seq_add8_ci.sv
// add8_ci: combinational 8-bit add with carry-in.
//   a, b : addend bytes
//   ci   : carry in
//   s    : sum byte
//   co   : unsigned carry out
//   v    : signed two's-complement overflow of this byte as an MS byte
module add8_ci
   import add_pkg::*;
(
   input  byte_t a,
   input  byte_t b,
   input  logic  ci,
   output byte_t s,
   output logic  co,
   output logic  v
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};

   // Overflow iff both addends share a sign and the result sign differs.
   assign v = (a[BYTE_W-1] == b[BYTE_W-1]) && (s[BYTE_W-1] != a[BYTE_W-1]);
endmodule

// File: rtl/mbyte_add_seq.sv
// mbyte_add_seq: NBYTES-wide add done one byte per accept, LS byte first,
// carry held in carry_q between bytes. A single output register decouples
// the upstream and downstream handshakes.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   clear : synchronous abort of the in-flight operand and pending output
//   bus   : byte-stream slave (see mbyte_add_seq_if)
module mbyte_add_seq
   import add_pkg::*;
#(
   parameter int NBYTES = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   mbyte_add_seq_if.slave bus
);
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

   add_state_e    state;
   logic [CW-1:0] cnt;
   logic          carry_q;
   byte_t         s;
   logic          c;
   logic          v;
   logic          accept;
   logic          last;

   // Pipe-register ready: depends only on our own register and out_ready.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last         = (cnt == LAST_IDX);

   add8_ci u_add (
      .a  (bus.in_a),
      .b  (bus.in_b),
      .ci (carry_q),
      .s  (s),
      .co (c),
      .v  (v)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         carry_q       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_last  <= 1'b0;
         bus.carry_out <= 1'b0;
         bus.ovf       <= 1'b0;
      end else if (clear) begin
         // Abort wins over any byte presented this cycle.
         state         <= IDLE;
         cnt           <= '0;
         carry_q       <= 1'b0;
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_sum   <= s;
         bus.out_last  <= last;
         bus.carry_out <= last & c;
         bus.ovf       <= last & v;
         if (last) begin
            // Operand done: next accept is byte 0 with a clean carry.
            cnt     <= '0;
            carry_q <= 1'b0;
         end else begin
            cnt     <= cnt + CW'(1);
            carry_q <= c;
         end
         case (state)
            IDLE:    state <= last ? IDLE : RUN;
            RUN:     state <= last ? IDLE : RUN;
            default: state <= IDLE;
         endcase
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mbyte_add_seq.sv
module tb_mbyte_add_seq;
   logic clk = 1'b0;
   logic reset;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   mbyte_add_seq_if bus ();

   mbyte_add_seq #(.NBYTES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   // Stream one 4-byte operand with out_ready=1, checking each sum byte the
   // cycle after it is accepted. exp_sum / co / ov are hand-computed.
   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_sum, input logic co, input logic ov);
      logic [31:0] av, bv, ev;
      av = a; bv = b; ev = exp_sum;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(av[8*k +: 8], bv[8*k +: 8]);
         tick();
         chk($sformatf("%s.vld%0d", tag, k), bus.out_valid, 1);
         chk($sformatf("%s.sum%0d", tag, k), bus.out_sum, ev[8*k +: 8]);
         chk($sformatf("%s.last%0d", tag, k), bus.out_last, (k == 3) ? 1 : 0);
         chk($sformatf("%s.co%0d", tag, k), bus.carry_out, (k == 3) ? co : 1'b0);
         chk($sformatf("%s.ovf%0d", tag, k), bus.ovf, (k == 3) ? ov : 1'b0);
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst.vld",   bus.out_valid, 0);
      chk("rst.rdy",   bus.in_ready,  1);
      chk("rst.sum",   bus.out_sum,   0);
      chk("rst.last",  bus.out_last,  0);
      chk("rst.co",    bus.carry_out, 0);
      chk("rst.ovf",   bus.ovf,       0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Carry across bytes 0->1, then back-to-back operands.
      op("ff1",   32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
      op("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
      op("noleak",32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
      op("sovf",  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);

      // Idle with out_ready=1 drains the register.
      tick();
      chk("drain.vld", bus.out_valid, 0);

      // Backpressure: 0x12345678 + 0x11111111 = 0x23456789.
      bus.out_ready = 1'b1;
      drive(8'h78, 8'h11); tick();
      chk("bp.sum0", bus.out_sum, 8'h89);
      drive(8'h56, 8'h11); tick();
      chk("bp.sum1", bus.out_sum, 8'h67);
      drive(8'h34, 8'h11);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp.rdy%0d", i), bus.in_ready, 0);
         chk($sformatf("bp.hold%0d", i), bus.out_sum, 8'h67);
         chk($sformatf("bp.vld%0d", i), bus.out_valid, 1);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp.rel.rdy", bus.in_ready, 1);
      tick();
      chk("bp.sum2",  bus.out_sum,  8'h45);
      chk("bp.last2", bus.out_last, 0);
      drive(8'h12, 8'h11); tick();
      chk("bp.sum3",  bus.out_sum,  8'h23);
      chk("bp.last3", bus.out_last, 1);
      chk("bp.co3",   bus.carry_out, 0);
      bus.in_valid = 1'b0;

      // Clear after byte 2 of 0x01010101 + 0x01010101.
      drive(8'h01, 8'h01); tick();
      drive(8'h01, 8'h01); tick();
      drive(8'h01, 8'h01); tick();
      chk("clr.sum2", bus.out_sum, 8'h02);
      drive(8'h01, 8'h01);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr.vld", bus.out_valid, 0);
      op("postclr", 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);

      // Async reset mid-operand with a live carry (0xFF + 0x01 on byte 0).
      drive(8'hFF, 8'h01); tick();
      chk("ar.pre.sum", bus.out_sum, 8'h00);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar.vld",  bus.out_valid, 0);
      chk("ar.sum",  bus.out_sum,   0);
      chk("ar.last", bus.out_last,  0);
      chk("ar.co",   bus.carry_out, 0);
      chk("ar.ovf",  bus.ovf,       0);
      chk("ar.rdy",  bus.in_ready,  1);
      @(negedge clk);
      reset = 1'b0;
      tick();
      op("postrst", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
